// File: rtl/arch_map_table_nway_if.sv
// Retirement map table bundle: retire slots and recovery request in, freelist returns,
// map copy-out stream and sticky error flags out. No backpressure anywhere on this bus.
interface arch_map_table_nway_if #(
   parameter int N_ARCH   = 32,
   parameter int N_PHYS   = 64,
   parameter int RETIRE_W = 2,
   parameter int COPY_W   = 8,
   parameter int AW       = $clog2(N_ARCH),
   parameter int PW       = $clog2(N_PHYS)
);
   logic [RETIRE_W-1:0]          retire_valid;
   logic [RETIRE_W-1:0][AW-1:0]  retire_arch;
   logic [RETIRE_W-1:0][PW-1:0]  retire_tnew;
   logic [RETIRE_W-1:0][PW-1:0]  retire_told;
   logic                         recover_req;

   logic [RETIRE_W-1:0]          free_valid;
   logic [RETIRE_W-1:0][PW-1:0]  free_tag;
   logic                         copy_valid;
   logic [AW-1:0]                copy_base;
   logic [COPY_W-1:0][PW-1:0]    copy_tags;
   logic                         recover_busy;
   logic [N_ARCH-1:0][PW-1:0]    map_tags;
   logic                         err_told;
   logic                         err_proto;

   modport master (
      output retire_valid, retire_arch, retire_tnew, retire_told, recover_req,
      input  free_valid, free_tag, copy_valid, copy_base, copy_tags,
      input  recover_busy, map_tags, err_told, err_proto
   );

   modport slave (
      input  retire_valid, retire_arch, retire_tnew, retire_told, recover_req,
      output free_valid, free_tag, copy_valid, copy_base, copy_tags,
      output recover_busy, map_tags, err_told, err_proto
   );
endinterface

// File: rtl/arch_map_table_nway.sv
// Committed arch->phys map: up to RETIRE_W in-order retires/cycle, frees 1 cycle later; copy-out
// of N_ARCH/COPY_W chunks starting 1 cycle after recover_req. No backpressure: consumer takes every chunk.
module arch_map_table_nway #(
   parameter int N_ARCH   = 32,
   parameter int N_PHYS   = 64,
   parameter int RETIRE_W = 2,
   parameter int COPY_W   = 8,
   parameter int AW       = $clog2(N_ARCH),
   parameter int PW       = $clog2(N_PHYS)
) (
   input  logic                  clock,
   input  logic                  reset,
   arch_map_table_nway_if.slave  bus
);
   localparam int NCHUNK = N_ARCH / COPY_W;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic {IDLE, COPY} state_t;

   state_t                       state_q, state_d;
   logic [CW-1:0]                chunk_q, chunk_d;
   logic [N_ARCH-1:0][PW-1:0]    map_q, map_d;
   logic [RETIRE_W-1:0]          free_valid_q, free_valid_d;
   logic [RETIRE_W-1:0][PW-1:0]  free_tag_q, free_tag_d;
   logic                         copy_valid_q, copy_valid_d;
   logic [AW-1:0]                copy_base_q, copy_base_d;
   logic [COPY_W-1:0][PW-1:0]    copy_tags_q, copy_tags_d;
   logic                         busy_q, busy_d;
   logic                         err_told_q, err_told_d;
   logic                         err_proto_q, err_proto_d;
   logic                         emit;
   int                           base;

   always_comb begin
      state_d      = state_q;
      chunk_d      = chunk_q;
      map_d        = map_q;
      free_valid_d = '0;
      free_tag_d   = '0;
      copy_valid_d = 1'b0;
      copy_base_d  = '0;
      copy_tags_d  = '0;
      busy_d       = 1'b0;
      err_told_d   = err_told_q;
      err_proto_d  = err_proto_q;
      emit         = 1'b0;
      base         = 0;

      if (state_q == IDLE) begin
         // Running view: a later slot to the same arch displaces the earlier slot's tnew.
         for (int k = 0; k < RETIRE_W; k++) begin
            if (bus.retire_valid[k] && (bus.retire_arch[k] != '0)) begin
               free_valid_d[k] = 1'b1;
               free_tag_d[k]   = map_d[bus.retire_arch[k]];
               if (map_d[bus.retire_arch[k]] != bus.retire_told[k]) begin
                  err_told_d = 1'b1;
               end
               map_d[bus.retire_arch[k]] = bus.retire_tnew[k];
            end
         end
         if (bus.recover_req) begin
            state_d = COPY;
            chunk_d = '0;
            emit    = 1'b1;
         end
      end else begin
         if (|bus.retire_valid) begin
            err_proto_d = 1'b1;
         end
         if (chunk_q == CW'(NCHUNK - 1)) begin
            state_d = IDLE;
         end else begin
            chunk_d = chunk_q + CW'(1);
            emit    = 1'b1;
         end
      end

      // First chunk is sourced from map_d so a same-cycle retire shows up in the copy.
      if (emit) begin
         base         = int'(chunk_d) * COPY_W;
         copy_valid_d = 1'b1;
         busy_d       = 1'b1;
         copy_base_d  = AW'(base);
         for (int j = 0; j < COPY_W; j++) begin
            copy_tags_d[j] = map_d[AW'(base + j)];
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         chunk_q      <= '0;
         for (int i = 0; i < N_ARCH; i++) begin
            map_q[i] <= PW'(i);
         end
         free_valid_q <= '0;
         free_tag_q   <= '0;
         copy_valid_q <= 1'b0;
         copy_base_q  <= '0;
         copy_tags_q  <= '0;
         busy_q       <= 1'b0;
         err_told_q   <= 1'b0;
         err_proto_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         chunk_q      <= chunk_d;
         map_q        <= map_d;
         free_valid_q <= free_valid_d;
         free_tag_q   <= free_tag_d;
         copy_valid_q <= copy_valid_d;
         copy_base_q  <= copy_base_d;
         copy_tags_q  <= copy_tags_d;
         busy_q       <= busy_d;
         err_told_q   <= err_told_d;
         err_proto_q  <= err_proto_d;
      end
   end

   assign bus.free_valid   = free_valid_q;
   assign bus.free_tag     = free_tag_q;
   assign bus.copy_valid   = copy_valid_q;
   assign bus.copy_base    = copy_base_q;
   assign bus.copy_tags    = copy_tags_q;
   assign bus.recover_busy = busy_q;
   assign bus.map_tags     = map_q;
   assign bus.err_told     = err_told_q;
   assign bus.err_proto    = err_proto_q;
endmodule

// File: tb/tb_arch_map_table_nway.sv
// Bench for arch_map_table_nway: directed steps plus random retires against an array-based
// map model; copy-out, illegal-in-copy and mid-copy reset scenarios.
module tb_arch_map_table_nway;
   localparam int N_ARCH   = 32;
   localparam int N_PHYS   = 64;
   localparam int RETIRE_W = 2;
   localparam int COPY_W   = 8;
   localparam int AW       = 5;
   localparam int PW       = 6;
   localparam int NCHUNK   = N_ARCH / COPY_W;

   logic clock = 1'b0;
   logic reset = 1'b0;

   arch_map_table_nway_if #(.N_ARCH(N_ARCH), .N_PHYS(N_PHYS), .RETIRE_W(RETIRE_W),
                            .COPY_W(COPY_W)) bus ();

   arch_map_table_nway #(.N_ARCH(N_ARCH), .N_PHYS(N_PHYS), .RETIRE_W(RETIRE_W),
                         .COPY_W(COPY_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   int                  nvec = 0;
   int                  nerr = 0;
   int                  mm [N_ARCH];
   logic [RETIRE_W-1:0] exp_fv;
   int                  exp_ft [RETIRE_W];
   bit                  exp_et = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      bus.retire_valid = '0;
      bus.retire_arch  = '0;
      bus.retire_tnew  = '0;
      bus.retire_told  = '0;
      bus.recover_req  = 1'b0;
   endtask

   task automatic set_slot(input int k, input bit v, input int a, input int tn, input int to);
      bus.retire_valid[k] = v;
      bus.retire_arch[k]  = AW'(a);
      bus.retire_tnew[k]  = PW'(tn);
      bus.retire_told[k]  = PW'(to);
   endtask

   task automatic model_identity();
      for (int i = 0; i < N_ARCH; i++) mm[i] = i;
   endtask

   // Expected frees/map for the retire inputs currently driven, assuming IDLE.
   task automatic model_retire();
      exp_fv = '0;
      for (int k = 0; k < RETIRE_W; k++) begin
         int a;
         exp_ft[k] = 0;
         a = int'(bus.retire_arch[k]);
         if (bus.retire_valid[k] && a != 0) begin
            exp_fv[k] = 1'b1;
            exp_ft[k] = mm[a];
            if (mm[a] != int'(bus.retire_told[k])) exp_et = 1'b1;
            mm[a] = int'(bus.retire_tnew[k]);
         end
      end
   endtask

   task automatic chk_free(input string tag);
      chk({tag, ".free_valid"}, 64'(bus.free_valid), 64'(exp_fv));
      for (int k = 0; k < RETIRE_W; k++)
         if (exp_fv[k]) chk($sformatf("%s.free_tag%0d", tag, k), 64'(bus.free_tag[k]), 64'(exp_ft[k]));
      chk({tag, ".err_told"}, 64'(bus.err_told), 64'(exp_et));
   endtask

   task automatic chk_map(input string tag);
      for (int i = 0; i < N_ARCH; i++)
         chk($sformatf("%s.map%0d", tag, i), 64'(bus.map_tags[i]), 64'(mm[i]));
   endtask

   task automatic chk_chunk(input string tag, input int c);
      chk($sformatf("%s.c%0d.valid", tag, c), 64'(bus.copy_valid), 64'd1);
      chk($sformatf("%s.c%0d.busy", tag, c), 64'(bus.recover_busy), 64'd1);
      chk($sformatf("%s.c%0d.base", tag, c), 64'(bus.copy_base), 64'(c * COPY_W));
      for (int j = 0; j < COPY_W; j++)
         chk($sformatf("%s.c%0d.tag%0d", tag, c, j), 64'(bus.copy_tags[j]), 64'(mm[c * COPY_W + j]));
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, ".busy"}, 64'(bus.recover_busy), 64'd0);
      chk({tag, ".copy_valid"}, 64'(bus.copy_valid), 64'd0);
   endtask

   initial begin
      idle_inputs();
      model_identity();

      // Reset state
      #12;
      chk_map("rst");
      chk("rst.free_valid", 64'(bus.free_valid), 64'd0);
      chk("rst.free_tag", 64'(bus.free_tag), 64'd0);
      chk("rst.copy_base", 64'(bus.copy_base), 64'd0);
      chk("rst.copy_tags", 64'(bus.copy_tags), 64'd0);
      chk("rst.err_proto", 64'(bus.err_proto), 64'd0);
      chk_quiet("rst");
      chk("rst.err_told", 64'(bus.err_told), 64'd0);
      reset = 1'b1;
      tick();

      // Single retire
      set_slot(0, 1'b1, 5, 40, 5);
      model_retire();
      tick();
      idle_inputs();
      chk_free("ret5");
      chk("ret5.tag_const", 64'(bus.free_tag[0]), 64'd5);
      chk("ret5.map_const", 64'(bus.map_tags[5]), 64'd40);
      chk_map("ret5");
      model_retire();
      tick();
      chk_free("ret5_hold");

      // Two slots to the same arch: slot1 frees slot0's tnew
      set_slot(0, 1'b1, 3, 33, 3);
      set_slot(1, 1'b1, 3, 34, 33);
      model_retire();
      tick();
      idle_inputs();
      chk_free("dual");
      chk("dual.tag1_const", 64'(bus.free_tag[1]), 64'd33);
      chk("dual.map3_const", 64'(bus.map_tags[3]), 64'd34);
      chk_map("dual");

      // Random retires with correct told values; err_told must stay clear
      for (int n = 0; n < 150; n++) begin
         int sh [N_ARCH];
         sh = mm;
         for (int k = 0; k < RETIRE_W; k++) begin
            bit v;
            int a, tn, to;
            v  = ($urandom % 4) != 0;
            a  = $urandom % N_ARCH;
            tn = $urandom % N_PHYS;
            to = $urandom % N_PHYS;
            if (v && a != 0) begin
               to = sh[a];
               sh[a] = tn;
            end
            set_slot(k, v, a, tn, to);
         end
         model_retire();
         tick();
         idle_inputs();
         chk_free($sformatf("rnd%0d", n));
         chk_map($sformatf("rnd%0d", n));
      end
      chk("rnd.err_told_const", 64'(bus.err_told), 64'd0);

      // Arch 0 never remapped
      set_slot(0, 1'b1, 0, 50, 0);
      model_retire();
      tick();
      idle_inputs();
      chk_free("zero");
      chk("zero.map0_const", 64'(bus.map_tags[0]), 64'd0);

      // Told mismatch still updates the map
      set_slot(0, 1'b1, 7, 21, (mm[7] == 9) ? 10 : 9);
      model_retire();
      tick();
      idle_inputs();
      chk_free("told");
      chk("told.err_const", 64'(bus.err_told), 64'd1);
      chk("told.map7_const", 64'(bus.map_tags[7]), 64'd21);
      chk_map("told");

      // Copy-out with simultaneous retire
      set_slot(0, 1'b1, 2, 60, mm[2]);
      bus.recover_req = 1'b1;
      model_retire();
      tick();
      idle_inputs();
      chk_free("cp");
      chk_chunk("cp", 0);
      chk("cp.tag2_const", 64'(bus.copy_tags[2]), 64'd60);
      for (int c = 1; c < NCHUNK; c++) begin
         tick();
         chk_chunk("cp", c);
      end
      tick();
      chk_quiet("cp.end");

      // Retire and recover_req during COPY are ignored
      bus.recover_req = 1'b1;
      tick();
      idle_inputs();
      chk_chunk("ill", 0);
      set_slot(0, 1'b1, 4, 11, mm[4]);
      set_slot(1, 1'b1, 9, 12, mm[9]);
      bus.recover_req = 1'b1;
      tick();
      idle_inputs();
      chk_chunk("ill", 1);
      chk("ill.free_valid", 64'(bus.free_valid), 64'd0);
      chk("ill.err_proto", 64'(bus.err_proto), 64'd1);
      chk_map("ill");
      for (int c = 2; c < NCHUNK; c++) begin
         tick();
         chk_chunk("ill", c);
      end
      tick();
      chk_quiet("ill.end");
      chk_map("ill.end");

      // Reset during chunk 2
      bus.recover_req = 1'b1;
      tick();
      idle_inputs();
      chk_chunk("mid", 0);
      tick();
      chk_chunk("mid", 1);
      tick();
      chk_chunk("mid", 2);
      #2;
      reset = 1'b0;
      #1;
      model_identity();
      exp_et = 1'b0;
      chk_quiet("mid.rst");
      chk("mid.err_told", 64'(bus.err_told), 64'd0);
      chk("mid.err_proto", 64'(bus.err_proto), 64'd0);
      chk_map("mid.rst");
      @(negedge clock);
      reset = 1'b1;
      tick();
      chk_quiet("mid.idle");
      set_slot(0, 1'b1, 5, 41, 5);
      model_retire();
      tick();
      idle_inputs();
      chk_free("mid.ret");
      chk("mid.ret.err_proto", 64'(bus.err_proto), 64'd0);
      chk_map("mid.ret");
      chk_quiet("mid.ret");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/arch_map_table_nway.md
# arch_map_table_nway

Parametrised retirement (architectural) map table for the out-of-order core. It holds the committed arch-to-physical tag mapping and applies up to RETIRE_W in-order retirements per cycle, reporting each displaced tag to the freelist. On a recovery request it streams the whole committed map, COPY_W entries per cycle, to the speculative map table.

## Interface
- N_ARCH, 32: architectural registers. Power of two, multiple of COPY_W.
- N_PHYS, 64: physical tags. Must be at least N_ARCH.
- RETIRE_W, 2: retirement slots per cycle. Slot 0 is oldest.
- COPY_W, 8: map entries streamed per recovery cycle.
- AW, $clog2(N_ARCH): arch index width (derived).
- PW, $clog2(N_PHYS): tag width (derived).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- retire_valid  in  RETIRE_W  per-slot retire strobe.
- retire_arch  in  RETIRE_W×AW  destination arch register.
- retire_tnew  in  RETIRE_W×PW  new committed tag.
- retire_told  in  RETIRE_W×PW  tag the ROB expects to be displaced.
- recover_req  in  1  single-cycle request to start a map copy-out.
- free_valid  out  RETIRE_W  registered: displaced tag is valid.
- free_tag  out  RETIRE_W×PW  registered: displaced tag, sent to the freelist.
- copy_valid  out  1  a copy chunk is on copy_base/copy_tags.
- copy_base  out  AW  first arch index of the chunk.
- copy_tags  out  COPY_W×PW  tags for copy_base .. copy_base+COPY_W-1.
- recover_busy  out  1  copy-out in progress.
- map_tags  out  N_ARCH×PW  current committed map (debug).
- err_told  out  1  sticky: a displaced tag differed from retire_told.
- err_proto  out  1  sticky: a retire was attempted while busy.

## Operation
- **Reset** (reset=0, asynchronous):
  - tag[i] = i.
  - free_valid=0, free_tag=0, copy_valid=0, copy_base=0, copy_tags=0, recover_busy=0.
  - err_told=0, err_proto=0. State is IDLE.
- **Retire** (IDLE only). Slots are processed in order 0..RETIRE_W-1 against a running view of the map:
  - Skip the slot if its valid is 0 or retire_arch==0. Arch register 0 is never remapped and never frees a tag.
  - Otherwise the displaced value d = running map[retire_arch]. Then running map[retire_arch] = retire_tnew.
  - Next cycle: free_valid[k]=1 and free_tag[k]=d.
  - If d != retire_told[k], set err_told. The map update still occurs.
  - Same arch in several slots: the youngest slot wins the final map. Each earlier slot's tnew is freed by the following slot.
- **States**: IDLE and COPY.
  - IDLE → COPY on recover_req.
  - COPY → IDLE after the chunk with copy_base = N_ARCH-COPY_W is emitted.
- **Copy-out** (COPY state):
  - Each cycle emits chunk c: copy_valid=1, copy_base = c·COPY_W, copy_tags from the current map.
  - Chunk counter c runs 0..N_ARCH/COPY_W-1 with no wrap beyond the last chunk.
  - recover_busy=1 throughout COPY.
- **Simultaneous events**:
  - recover_req with retires in IDLE: retires are applied first, and the copy reflects the post-retire map.
  - recover_req while in COPY: ignored. No restart.
  - retire_valid set while in COPY: ignored (no map change, no free), and err_proto is set.
- **Errors**: err_told and err_proto clear only on reset.
- **Reset mid-copy**: state returns to IDLE, the map is reinitialised, and copy_valid drops asynchronously.

## Timing
- Map update happens at the retire edge. map_tags shows the new value in the following cycle.
- free_valid/free_tag: 1-cycle latency after the retire edge, held for exactly one cycle.
- recover_req sampled at edge T gives:
  - recover_busy=1 and first chunk valid from T+1.
  - last chunk at T+N_ARCH/COPY_W.
  - recover_busy=0 at T+N_ARCH/COPY_W+1.
  - Default latency is 4 busy cycles.
- No back-pressure: the consumer must accept one chunk per cycle.
- All outputs are registered except map_tags, which is the register array itself.

## Test plan
- **Reset**: release reset → map_tags[i]=i, all outputs 0; retire arch 5 tnew 40 told 5 → next cycle free_valid[0]=1, free_tag[0]=5, map_tags[5]=40.
- **Dual retire, same arch**: slot0 (arch 3, tnew 33, told 3) and slot1 (arch 3, tnew 34, told 33) → free_tag = {3, 33}, map_tags[3]=34, err_told=0.
- **Zero register**: slot0 arch 0 tnew 50 → free_valid[0]=0, map_tags[0]=0. Told mismatch: arch 7 told 9 → err_told=1, map_tags[7] updated anyway.
- **Copy-out**: recover_req with a simultaneous retire of arch 2 to tag 60 → four chunks follow, copy_base 0, 8, 16, 24; chunk 0 carries tag 60 at index 2; recover_busy high exactly 4 cycles.
- **Illegal during copy**: retire_valid and a second recover_req during COPY → err_proto=1, map unchanged, sequence not restarted.
- **Reset mid-copy**: assert reset during chunk 2 → copy_valid=0 immediately, map back to identity, state IDLE.
